// File: rtl/param_sram_2p.sv
// Simple dual-port synchronous RAM with byte-lane writes, write-first same-address
// bypass, a registered read-valid flag and a hardware zero-fill engine.
module param_sram_2p #(
    parameter  int DATA_W = 16,
    parameter  int ADDR_W = 4,
    localparam int NBE    = DATA_W / 8
) (
    input  logic              clok,
    input  logic              rst,
    input  logic              wri,
    input  logic [ADDR_W-1:0] wr_add,
    input  logic [DATA_W-1:0] data_in,
    input  logic [NBE-1:0]    be,
    input  logic              rd,
    input  logic [ADDR_W-1:0] rd_add,
    input  logic              clr,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              busy
);

    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {
        S_FILL  = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W:0]     r_cnt;
    logic [ADDR_W:0]     w_cnt_nxt;

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   r_data_out;
    logic                r_rd_valid;

    logic                w_fill;
    logic                w_usr_wr;
    logic                w_usr_rd;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_wdata;
    logic [NBE-1:0]      w_mem_mask;
    logic [DATA_W-1:0]   w_rd_data;

    always_ff @(posedge clok or posedge rst) begin
        if (rst) begin
            r_state <= S_FILL;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The wide counter lets the DEPTH-1 terminal compare see the last address
    // without wrapping back to zero first.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_FILL: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_READY;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_READY: begin
                if (clr) begin
                    w_state_nxt = S_FILL;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_FILL;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // A clr cycle swallows any user access issued alongside it.
    always_comb begin
        w_fill      = (r_state == S_FILL);
        w_usr_wr    = !w_fill && wri && !clr;
        w_usr_rd    = !w_fill && rd && !clr;
        w_mem_we    = w_fill || w_usr_wr;
        w_mem_addr  = w_fill ? r_cnt[ADDR_W-1:0] : wr_add;
        w_mem_wdata = w_fill ? '0 : data_in;
        w_mem_mask  = w_fill ? '1 : be;
    end

    always_ff @(posedge clok) begin
        if (w_mem_we) begin
            for (int i = 0; i < NBE; i++) begin
                if (w_mem_mask[i]) begin
                    r_mem[w_mem_addr][8*i +: 8] <= w_mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // Write-first bypass: enabled lanes of a same-address write replace stale data.
    always_comb begin
        w_rd_data = r_mem[rd_add];
        for (int i = 0; i < NBE; i++) begin
            if (w_usr_wr && (wr_add == rd_add) && be[i]) begin
                w_rd_data[8*i +: 8] = data_in[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clok or posedge rst) begin
        if (rst) begin
            r_data_out <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_usr_rd;
            if (w_usr_rd) begin
                r_data_out <= w_rd_data;
            end
        end
    end

    assign data_out = r_data_out;
    assign rd_valid = r_rd_valid;
    assign busy     = (r_state == S_FILL);

endmodule

// File: tb/tb_param_sram_2p.sv
// Directed self-checking bench for param_sram_2p (DATA_W=16, ADDR_W=4).
module tb_param_sram_2p;

    logic        clok;
    logic        rst;
    logic        wri;
    logic [3:0]  wr_add;
    logic [15:0] data_in;
    logic [1:0]  be;
    logic        rd;
    logic [3:0]  rd_add;
    logic        clr;
    logic [15:0] data_out;
    logic        rd_valid;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    param_sram_2p #(.DATA_W(16), .ADDR_W(4)) dut (
        .clok     (clok),
        .rst      (rst),
        .wri      (wri),
        .wr_add   (wr_add),
        .data_in  (data_in),
        .be       (be),
        .rd       (rd),
        .rd_add   (rd_add),
        .clr      (clr),
        .data_out (data_out),
        .rd_valid (rd_valid),
        .busy     (busy)
    );

    initial clok = 1'b0;
    always #5 clok = ~clok;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic wr_word(input logic [3:0] a, input logic [15:0] d, input logic [1:0] b);
        wri = 1'b1; wr_add = a; data_in = d; be = b;
        @(negedge clok);
        wri = 1'b0;
    endtask

    task automatic rd_word(input string tag, input logic [3:0] a, input logic [15:0] exp);
        rd = 1'b1; rd_add = a;
        @(negedge clok);
        rd = 1'b0;
        chk({tag, "_vld"}, {31'd0, rd_valid}, 32'd1);
        chk({tag, "_dat"}, {16'd0, data_out}, {16'd0, exp});
    endtask

    task automatic rd_all_zero(input string tag);
        for (int a = 0; a < 16; a++) begin
            rd_word($sformatf("%s_a%0d", tag, a), 4'(a), 16'h0000);
        end
    endtask

    // Called right after rst falls at a negedge: busy must cover 16 cycles in total.
    task automatic rst_fill(input string tag);
        #1;
        chk({tag, "_busy0"}, {31'd0, busy}, 32'd1);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clok);
            chk($sformatf("%s_busy%0d", tag, k), {31'd0, busy}, (k <= 15) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; wri = 1'b0; wr_add = '0; data_in = '0; be = '0;
        rd = 1'b0; rd_add = '0; clr = 1'b0;
        repeat (2) @(negedge clok);

        // 1: reset state, fill timing, all-zero contents
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_dout", {16'd0, data_out}, 32'd0);
        chk("rst_vld",  {31'd0, rd_valid}, 32'd0);
        rst = 1'b0;
        rst_fill("t1");
        rd_all_zero("t1_rd");

        // 2: full-word write and readback
        wr_word(4'd3, 16'hD2C3, 2'b11);
        rd_word("t2_a0", 4'd0, 16'h0000);
        rd_word("t2_a3", 4'd3, 16'hD2C3);
        @(negedge clok);
        chk("t2_vld_drop", {31'd0, rd_valid}, 32'd0);
        chk("t2_hold", {16'd0, data_out}, 32'h0000D2C3);

        // 3: byte enables
        wr_word(4'd5, 16'hAAAA, 2'b11);
        wr_word(4'd5, 16'h1234, 2'b01);
        rd_word("t3_lo", 4'd5, 16'hAA34);
        wr_word(4'd5, 16'hFFFF, 2'b00);
        rd_word("t3_none", 4'd5, 16'hAA34);

        // 4: same-address bypass, then different-address independence
        wr_word(4'd7, 16'h5555, 2'b11);
        rd = 1'b1; rd_add = 4'd7;
        wri = 1'b1; wr_add = 4'd7; data_in = 16'h9ABC; be = 2'b10;
        @(negedge clok);
        rd = 1'b0; wri = 1'b0;
        chk("t4_byp_vld", {31'd0, rd_valid}, 32'd1);
        chk("t4_byp_dat", {16'd0, data_out}, 32'h00009A55);
        rd_word("t4_after", 4'd7, 16'h9A55);
        rd = 1'b1; rd_add = 4'd3;
        wri = 1'b1; wr_add = 4'd8; data_in = 16'h1111; be = 2'b11;
        @(negedge clok);
        rd = 1'b0; wri = 1'b0;
        chk("t4_diff_dat", {16'd0, data_out}, 32'h0000D2C3);
        rd_word("t4_a8", 4'd8, 16'h1111);

        // 5: clr restarts fill; user ports and a second clr are ignored while busy
        clr = 1'b1; rd = 1'b1; rd_add = 4'd3;
        wri = 1'b1; wr_add = 4'd9; data_in = 16'h7777; be = 2'b11;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clok);
            if (k == 1) begin clr = 1'b0; wri = 1'b0; end
            chk($sformatf("t5_busy%0d", k), {31'd0, busy}, (k <= 16) ? 32'd1 : 32'd0);
            chk($sformatf("t5_vld%0d", k), {31'd0, rd_valid}, 32'd0);
            if (k == 10) begin wri = 1'b1; wr_add = 4'd2; data_in = 16'hBEEF; be = 2'b11; end
            if (k == 11) wri = 1'b0;
            if (k == 12) clr = 1'b1;
            if (k == 13) clr = 1'b0;
            if (k == 16) rd = 1'b0;
        end
        chk("t5_hold", {16'd0, data_out}, 32'h00001111);
        rd_all_zero("t5_rd");

        // 6: reset in the middle of a fill
        wr_word(4'd1, 16'h4242, 2'b11);
        wr_word(4'd14, 16'hC0DE, 2'b11);
        wr_word(4'd15, 16'hF00D, 2'b11);
        rd_word("t6_pre", 4'd1, 16'h4242);
        clr = 1'b1;
        @(negedge clok);
        clr = 1'b0;
        repeat (7) @(negedge clok);
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", {31'd0, busy}, 32'd1);
        chk("t6_rst_dout", {16'd0, data_out}, 32'd0);
        chk("t6_rst_vld",  {31'd0, rd_valid}, 32'd0);
        @(negedge clok);
        chk("t6_rst_busy2", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        rst_fill("t6");
        rd_all_zero("t6_rd");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
